// File: rtl/sys_tick_watchdog_pkg.sv
// Shared types and constants for the tick-driven watchdog.
package sys_tick_watchdog_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_WARN     = 2'd2,
    ST_EXPIRED  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_CONTROL  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_TIMEOUT  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_WARN     = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_KICK     = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_TICK_CNT = 3'd5;

  localparam int unsigned STAT_WARNED  = 0;
  localparam int unsigned STAT_EXPIRED = 1;
  localparam int unsigned STAT_RUNNING = 2;
  localparam int unsigned STAT_BAD_KEY = 3;

  localparam int unsigned CTRL_IRQ_EN = 0;
  localparam int unsigned CTRL_ENABLE = 1;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sys_tick_watchdog_if.sv
// Avalon-MM register port of the watchdog.
interface sys_tick_watchdog_if;
  import sys_tick_watchdog_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/sys_tick_watchdog_pulse.sv
// Loadable down-counter: holds pulse high for CYCLES clocks after load and
// strobes done in the last high cycle.
module sys_tick_watchdog_pulse #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic pulse,
  output logic done
);

  localparam int unsigned    CW       = $clog2(CYCLES + 1);
  localparam logic [CW-1:0]  LOAD_VAL = CW'(CYCLES);
  localparam logic [CW-1:0]  ONE      = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pulse = (cnt_q != '0);
  assign done  = (cnt_q == ONE);

endmodule

// File: rtl/sys_tick_watchdog.sv
// Tick-counting watchdog with warn interrupt and reset_req pulse.
// Optional SYS_TICK_WATCHDOG_BAD_KEY_EN: wrong kick key forces expiry.
module sys_tick_watchdog
  import sys_tick_watchdog_pkg::*;
#(
  parameter logic [15:0] DEFAULT_TIMEOUT    = 16'd10,
  parameter logic [15:0] DEFAULT_WARN       = 16'd8,
  parameter logic [15:0] KICK_KEY           = 16'hA5C3,
  parameter int unsigned RESET_PULSE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  sys_tick_watchdog_if.slave  avs,
  input  logic                tick_in,
  output logic                irq,
  output logic                reset_req
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [DATA_W-1:0] timeout_q, timeout_d;
  logic [DATA_W-1:0] warn_q, warn_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              tick_in_d_q;
  logic              irq_en_q, irq_en_d;
  logic              enable_q, enable_d;
  logic              warned_q, warned_d;
  logic              expired_q, expired_d;
  logic              bad_key_d;
  logic              status_bad_key;

  logic              tick;
  logic              wr, wr_status, wr_control, wr_timeout, wr_warn, wr_kick;
  logic              active, kick_ok, kick_bad, running;
  logic [DATA_W-1:0] cnt_inc;
  logic              pulse_load, pulse_done;

  assign tick       = tick_in & ~tick_in_d_q;
  assign wr         = avs.chipselect & ~avs.write_n;
  assign wr_status  = wr && (avs.address == ADDR_STATUS);
  assign wr_control = wr && (avs.address == ADDR_CONTROL);
  assign wr_timeout = wr && (avs.address == ADDR_TIMEOUT);
  assign wr_warn    = wr && (avs.address == ADDR_WARN);
  assign wr_kick    = wr && (avs.address == ADDR_KICK);
  assign active     = (state_q == ST_ARMED) || (state_q == ST_WARN);
  assign running    = active;
  assign kick_ok    = wr_kick && (avs.writedata == KICK_KEY);
  assign kick_bad   = wr_kick && (avs.writedata != KICK_KEY);
  assign cnt_inc    = sat_inc(tick_cnt_q);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    timeout_d  = timeout_q;
    warn_d     = warn_q;
    irq_en_d   = irq_en_q;
    enable_d   = enable_q;
    warned_d   = warned_q;
    expired_d  = expired_q;
    bad_key_d  = status_bad_key;
    pulse_load = 1'b0;

    if (wr_timeout) timeout_d = avs.writedata;
    if (wr_warn)    warn_d    = avs.writedata;
    if (wr_control) begin
      irq_en_d = avs.writedata[CTRL_IRQ_EN];
      enable_d = avs.writedata[CTRL_ENABLE];
    end
    // Clears come first so a same-cycle set event below ends up winning.
    if (wr_status) begin
      warned_d  = 1'b0;
      expired_d = 1'b0;
      bad_key_d = 1'b0;
    end

    unique case (state_q)
      ST_DISABLED: begin
        tick_cnt_d = '0;
        if (wr_control && avs.writedata[CTRL_ENABLE]) state_d = ST_ARMED;
      end
      ST_ARMED, ST_WARN: begin
        if (wr_control && !avs.writedata[CTRL_ENABLE]) begin
          state_d    = ST_DISABLED;
          tick_cnt_d = '0;
        end else if (kick_ok) begin
          state_d    = ST_ARMED;
          tick_cnt_d = '0;
        end
`ifdef SYS_TICK_WATCHDOG_BAD_KEY_EN
        else if (kick_bad) begin
          state_d    = ST_EXPIRED;
          pulse_load = 1'b1;
          bad_key_d  = 1'b1;
        end
`endif
        else if (tick) begin
          tick_cnt_d = cnt_inc;
          if (cnt_inc >= timeout_q) begin
            state_d    = ST_EXPIRED;
            pulse_load = 1'b1;
          end else if ((state_q == ST_ARMED) && (warn_q != '0) && (cnt_inc >= warn_q)) begin
            state_d  = ST_WARN;
            warned_d = 1'b1;
          end
        end
      end
      ST_EXPIRED: begin
        if (pulse_done) begin
          state_d    = ST_DISABLED;
          expired_d  = 1'b1;
          enable_d   = 1'b0;
          tick_cnt_d = '0;
        end
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  always_comb begin
    readdata_d = '0;
    case (avs.address)
      ADDR_STATUS: begin
        readdata_d[STAT_WARNED]  = warned_q;
        readdata_d[STAT_EXPIRED] = expired_q;
        readdata_d[STAT_RUNNING] = running;
        readdata_d[STAT_BAD_KEY] = status_bad_key;
      end
      ADDR_CONTROL: begin
        readdata_d[CTRL_IRQ_EN] = irq_en_q;
        readdata_d[CTRL_ENABLE] = enable_q;
      end
      ADDR_TIMEOUT:  readdata_d = timeout_q;
      ADDR_WARN:     readdata_d = warn_q;
      ADDR_TICK_CNT: readdata_d = tick_cnt_q;
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_DISABLED;
      tick_cnt_q  <= '0;
      timeout_q   <= DEFAULT_TIMEOUT;
      warn_q      <= DEFAULT_WARN;
      readdata_q  <= '0;
      tick_in_d_q <= 1'b0;
      irq_en_q    <= 1'b0;
      enable_q    <= 1'b0;
      warned_q    <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      timeout_q   <= timeout_d;
      warn_q      <= warn_d;
      readdata_q  <= readdata_d;
      tick_in_d_q <= tick_in;
      irq_en_q    <= irq_en_d;
      enable_q    <= enable_d;
      warned_q    <= warned_d;
      expired_q   <= expired_d;
    end
  end

`ifdef SYS_TICK_WATCHDOG_BAD_KEY_EN
  logic bad_key_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bad_key_q <= 1'b0;
    end else begin
      bad_key_q <= bad_key_d;
    end
  end
  assign status_bad_key = bad_key_q;
`else
  logic unused_bad_key;
  assign status_bad_key = 1'b0;
  assign unused_bad_key = bad_key_d ^ kick_bad;
`endif

  sys_tick_watchdog_pulse #(
    .CYCLES (RESET_PULSE_CYCLES)
  ) u_pulse (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pulse_load),
    .pulse   (reset_req),
    .done    (pulse_done)
  );

  assign avs.readdata = readdata_q;
  assign irq          = warned_q & irq_en_q;

endmodule
